// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the architectural PC, issues one imem word read per
// instruction and hands the fetched word and its PC to decode over valid/ready.
module ifu_fetch #(
   parameter logic [29:0] RESET_PC = 30'h0000_0C00,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [29:0]      imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic             inst_valid,
   output logic [31:0]      inst,
   output logic [29:0]      pc,
   input  logic             inst_ready,
   input  logic [29:0]      npc,
   output logic [CNT_W-1:0] fetch_cnt
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [29:0]      r_pc;
   logic [31:0]      r_inst;
   logic [CNT_W-1:0] r_fetch_cnt;
   logic             w_req;
   logic             w_valid;
   logic             w_capture;
   logic             w_accept;

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_valid     = 1'b0;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_REQ: begin
            w_req = 1'b1;
            if (imem_gnt) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               w_capture   = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            w_valid = 1'b1;
            if (inst_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_inst      <= '0;
         r_fetch_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) r_inst <= imem_rdata;
         // npc is only trusted on the accept edge; all PC arithmetic lives upstream.
         if (w_accept) begin
            r_pc        <= npc;
            r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
         end
      end
   end

   assign imem_req   = w_req & ~rst;
   assign inst_valid = w_valid & ~rst;
   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign inst       = r_inst;
   assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: stimulus plays the imem and decode sides, a
// scoreboard monitor checks every instruction accepted by decode.
module tb_ifu_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [29:0] pc;
   logic        inst_ready;
   logic [29:0] npc;
   logic [31:0] fetch_cnt;

   typedef struct packed {
      logic [31:0] inst;
      logic [29:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          exp_cnt  = 0;
   int          mon_cnt  = 0;
   logic [31:0] last_inst = '0;

   ifu_fetch #(.RESET_PC(30'h0000_0C00), .CNT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .pc          (pc),
      .inst_ready  (inst_ready),
      .npc         (npc),
      .fetch_cnt   (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Inputs change at posedge+1; everything is sampled at negedge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every decode accept must match the oldest pushed entry.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
         mon_cnt = 0;
      end else if (inst_valid && inst_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_unexpected_accept inst=%h pc=%h expected=none", inst, pc);
         end else begin
            e = sb.pop_front();
            chk("mon_inst", inst, e.inst);
            chk("mon_pc", {2'b00, pc}, {2'b00, e.pc});
         end
         chk("mon_cnt", fetch_cnt, mon_cnt);
         mon_cnt++;
      end
   end

   // One full fetch: grant after gd idle cycles, rvalid rd cycles after grant,
   // decode stalls hold cycles before accepting with nxt.
   task automatic do_fetch(input int gd, input int rd, input logic [31:0] data,
                           input logic [29:0] epc, input int hold,
                           input logic [29:0] nxt, input bit spur);
      for (int i = 0; i <= gd; i++) begin
         imem_gnt    = (i == gd);
         imem_rvalid = spur && (i == 0);
         imem_rdata  = 32'hBAD0_BAD0;
         @(negedge clk);
         chk("req_hi", imem_req, 1);
         chk("req_addr", {2'b00, imem_addr}, {2'b00, epc});
         chk("req_ivalid", inst_valid, 0);
         chk("req_inst_keep", inst, last_inst);
         chk("req_cnt", fetch_cnt, exp_cnt);
         cyc();
      end
      imem_gnt = 1'b0;
      for (int i = 1; i <= rd; i++) begin
         imem_rvalid = (i == rd);
         imem_rdata  = (i == rd) ? data : 32'hDEAD_BEEF;
         if (i == rd) sb.push_back('{inst: data, pc: epc});
         @(negedge clk);
         chk("wait_req", imem_req, 0);
         chk("wait_ivalid", inst_valid, 0);
         chk("wait_inst_keep", inst, last_inst);
         cyc();
      end
      imem_rvalid = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         inst_ready  = (i == hold);
         npc         = (i == hold) ? nxt : 30'($urandom);
         imem_rvalid = spur && (i == 0);
         imem_gnt    = spur && (i == 0);
         imem_rdata  = 32'hBAD1_BAD1;
         @(negedge clk);
         chk("hold_ivalid", inst_valid, 1);
         chk("hold_inst", inst, data);
         chk("hold_pc", {2'b00, pc}, {2'b00, epc});
         chk("hold_req", imem_req, 0);
         chk("hold_cnt", fetch_cnt, exp_cnt);
         cyc();
      end
      inst_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b0;
      exp_cnt++;
      last_inst = data;
   endtask

   task automatic chk_after_reset(input string tag);
      @(negedge clk);
      chk({tag, "_req"}, imem_req, 1);
      chk({tag, "_addr"}, {2'b00, imem_addr}, 32'h0000_0C00);
      chk({tag, "_ivalid"}, inst_valid, 0);
      chk({tag, "_inst"}, inst, 0);
      chk({tag, "_cnt"}, fetch_cnt, 0);
      exp_cnt   = 0;
      last_inst = '0;
      cyc();
   endtask

   initial begin
      rst         = 1'b1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      inst_ready  = 1'b0;
      npc         = '0;

      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_req", imem_req, 0);
         chk("rst_ivalid", inst_valid, 0);
         cyc();
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req", imem_req, 1);
      chk("post_rst_addr", {2'b00, imem_addr}, 32'h0000_0C00);
      chk("post_rst_cnt", fetch_cnt, 0);
      cyc();

      // zero-wait, backpressure, slow imem + branch redirect, spurious rvalid
      do_fetch(0, 1, 32'h2408_0005, 30'h0C00, 0, 30'h0C01, 1'b0);
      do_fetch(0, 1, 32'h8C09_0004, 30'h0C01, 5, 30'h0C02, 1'b0);
      do_fetch(3, 4, 32'h0109_5020, 30'h0C02, 1, 30'h0C10, 1'b1);
      do_fetch(0, 2, 32'h1000_FFFF, 30'h0C10, 0, 30'h0C11, 1'b1);

      // reset while waiting for imem data
      imem_gnt = 1'b1;
      @(negedge clk);
      chk("rw_req", imem_req, 1);
      chk("rw_addr", {2'b00, imem_addr}, 32'h0000_0C11);
      cyc();
      imem_gnt = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      chk("rw_rst_req", imem_req, 0);
      chk("rw_rst_ivalid", inst_valid, 0);
      cyc();
      rst = 1'b0;
      chk_after_reset("rw");

      do_fetch(1, 1, 32'h3C01_1234, 30'h0C00, 0, 30'h0C05, 1'b0);

      // reset while an instruction is held for decode
      imem_gnt = 1'b1;
      cyc();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hCAFE_F00D;
      sb.push_back('{inst: 32'hCAFE_F00D, pc: 30'h0C05});
      cyc();
      imem_rvalid = 1'b0;
      @(negedge clk);
      chk("rh_ivalid", inst_valid, 1);
      chk("rh_inst", inst, 32'hCAFE_F00D);
      cyc();
      rst = 1'b1;
      @(negedge clk);
      chk("rh_rst_ivalid", inst_valid, 0);
      chk("rh_rst_req", imem_req, 0);
      cyc();
      rst = 1'b0;
      chk_after_reset("rh");

      do_fetch(0, 1, 32'h2408_0007, 30'h0C00, 2, 30'h0C01, 1'b0);
      @(negedge clk);
      chk("final_cnt", fetch_cnt, 1);
      chk("final_addr", {2'b00, imem_addr}, 32'h0000_0C01);
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
